// File: rtl/score_mult_arbiter.sv
// Round-robin arbiter sharing one fixed-latency multiplier between the time-score
// and pairs-score requesters; returns a registered product per requester.
module score_mult_arbiter #(
   parameter int unsigned MULT_LATENCY = 2,
   parameter int unsigned OP_MAX       = 33
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_time,
   input  logic [5:0]  op_time,
   input  logic        req_pairs,
   input  logic [5:0]  op_pairs,
   output logic [5:0]  mult_a,
   output logic        mult_start,
   input  logic [12:0] mult_p,
   output logic [12:0] res_time,
   output logic        done_time,
   output logic [12:0] res_pairs,
   output logic        done_pairs,
   output logic        busy
);

   localparam int unsigned OP_W  = 6;
   localparam int unsigned P_W   = 13;
   localparam int unsigned CNT_W = 3;
   localparam logic        GRANT_TIME  = 1'b0;
   localparam logic        GRANT_PAIRS = 1'b1;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

   state_t             state_q, state_d;
   logic               sel_q, sel_d;
   logic               last_q, last_d;
   logic               abort_q, abort_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [OP_W-1:0]    mult_a_d;
   logic               mult_start_d;
   logic [P_W-1:0]     res_time_d, res_pairs_d;
   logic               done_time_d, done_pairs_d;
   logic               busy_d;

   logic               grant_pairs_c;
   logic [OP_W-1:0]    op_sel_c;
   logic [OP_W-1:0]    op_clamp_c;
   logic               req_sel_c;

   // Pairs wins only when it is alone or time was served last.
   assign grant_pairs_c = req_pairs && (!req_time || (last_q == GRANT_TIME));
   assign op_sel_c      = grant_pairs_c ? op_pairs : op_time;
   assign op_clamp_c    = (op_sel_c > OP_W'(OP_MAX)) ? OP_W'(OP_MAX) : op_sel_c;
   assign req_sel_c     = (sel_q == GRANT_PAIRS) ? req_pairs : req_time;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         sel_q      <= GRANT_TIME;
         last_q     <= GRANT_PAIRS;
         abort_q    <= 1'b0;
         cnt_q      <= '0;
         mult_a     <= '0;
         mult_start <= 1'b0;
         res_time   <= '0;
         res_pairs  <= '0;
         done_time  <= 1'b0;
         done_pairs <= 1'b0;
         busy       <= 1'b0;
      end else begin
         state_q    <= state_d;
         sel_q      <= sel_d;
         last_q     <= last_d;
         abort_q    <= abort_d;
         cnt_q      <= cnt_d;
         mult_a     <= mult_a_d;
         mult_start <= mult_start_d;
         res_time   <= res_time_d;
         res_pairs  <= res_pairs_d;
         done_time  <= done_time_d;
         done_pairs <= done_pairs_d;
         busy       <= busy_d;
      end
   end

   // Next-state and next-output logic; done pulses are launched on entry to DONE.
   always_comb begin
      state_d      = state_q;
      sel_d        = sel_q;
      last_d       = last_q;
      abort_d      = abort_q;
      cnt_d        = cnt_q;
      mult_a_d     = mult_a;
      mult_start_d = 1'b0;
      res_time_d   = res_time;
      res_pairs_d  = res_pairs;
      done_time_d  = 1'b0;
      done_pairs_d = 1'b0;

      case (state_q)
         IDLE: begin
            if (req_time || req_pairs) begin
               sel_d        = grant_pairs_c;
               mult_a_d     = op_clamp_c;
               mult_start_d = 1'b1;
               state_d      = ISSUE;
            end
         end
         ISSUE: begin
            cnt_d   = CNT_W'(MULT_LATENCY);
            state_d = WAIT;
         end
         WAIT: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               state_d = DONE;
               if (req_sel_c) begin
                  if (sel_q == GRANT_PAIRS) begin
                     res_pairs_d  = mult_p;
                     done_pairs_d = 1'b1;
                  end else begin
                     res_time_d  = mult_p;
                     done_time_d = 1'b1;
                  end
               end else begin
                  abort_d = 1'b1;
               end
            end
         end
         DONE: begin
            last_d  = sel_q;
            abort_d = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
   end

endmodule

// File: tb/tb_score_mult_arbiter.sv
// Directed bench for score_mult_arbiter with a behavioural x101 pipelined multiplier.
module tb_score_mult_arbiter;

   localparam int unsigned MULT_CONST   = 101;
   localparam int unsigned MULT_LATENCY = 2;
   localparam logic [12:0] JUNK         = 13'h1fff;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req_time = 1'b0;
   logic [5:0]  op_time = '0;
   logic        req_pairs = 1'b0;
   logic [5:0]  op_pairs = '0;
   logic [5:0]  mult_a;
   logic        mult_start;
   logic [12:0] mult_p;
   logic [12:0] res_time;
   logic        done_time;
   logic [12:0] res_pairs;
   logic        done_pairs;
   logic        busy;

   int n_checks = 0;
   int n_pass   = 0;

   logic [12:0] pipe [0:7];

   score_mult_arbiter #(.MULT_LATENCY(MULT_LATENCY), .OP_MAX(33)) dut (
      .clk(clk), .rst(rst),
      .req_time(req_time), .op_time(op_time),
      .req_pairs(req_pairs), .op_pairs(op_pairs),
      .mult_a(mult_a), .mult_start(mult_start), .mult_p(mult_p),
      .res_time(res_time), .done_time(done_time),
      .res_pairs(res_pairs), .done_pairs(done_pairs),
      .busy(busy)
   );

   always #5 clk = ~clk;

   // Multiplier model: product valid MULT_LATENCY cycles after mult_start, junk otherwise.
   always @(posedge clk) begin
      pipe[0] <= mult_start ? 13'(int'(mult_a) * MULT_CONST) : JUNK;
      for (int i = 1; i < 8; i++) pipe[i] <= pipe[i-1];
   end
   assign mult_p = pipe[MULT_LATENCY-1];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_done(input bit pairs, input int budget, output int cyc);
      cyc = -1;
      for (int c = 1; c <= budget; c++) begin
         step();
         if (pairs ? done_pairs : done_time) begin
            cyc = c;
            return;
         end
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic single_op(input bit pairs, input logic [5:0] op, input int exp_a,
                            input int exp_res, input string tag);
      int cyc;
      @(negedge clk);
      if (pairs) begin op_pairs = op; req_pairs = 1'b1; end
      else       begin op_time  = op; req_time  = 1'b1; end
      wait_done(pairs, 12, cyc);
      check({tag, "_lat"}, cyc, 4);
      check({tag, "_res"}, pairs ? res_pairs : res_time, exp_res);
      check({tag, "_a"}, mult_a, exp_a);
      check({tag, "_other"}, pairs ? done_time : done_pairs, 0);
      @(negedge clk);
      if (pairs) req_pairs = 1'b0;
      else       req_time  = 1'b0;
   endtask

   initial begin
      int cyc, nd, idle;

      #12;
      check("reset_outs", {mult_a, mult_start, res_time, done_time, res_pairs, done_pairs, busy}, 0);
      @(negedge clk);
      rst = 1'b1;

      // single time request
      @(negedge clk);
      op_time = 6'd12; req_time = 1'b1;
      step();
      check("t1_start", mult_start, 1);
      check("t1_busy", busy, 1);
      check("t1_a", mult_a, 12);
      wait_done(1'b0, 12, cyc);
      check("t1_lat", cyc, 3);
      check("t1_res", res_time, 1212);
      check("t1_dpairs", done_pairs, 0);
      @(negedge clk);
      req_time = 1'b0;
      step();
      check("t1_done_pulse", done_time, 0);
      check("t1_idle", busy, 0);
      check("t1_a_hold", mult_a, 12);

      // simultaneous first request after reset: time first, pairs 5 cycles later
      do_reset();
      @(negedge clk);
      op_time = 6'd5; op_pairs = 6'd20; req_time = 1'b1; req_pairs = 1'b1;
      wait_done(1'b0, 12, cyc);
      check("sim_t_lat", cyc, 4);
      check("sim_t_res", res_time, 505);
      @(negedge clk);
      req_time = 1'b0;
      wait_done(1'b1, 12, cyc);
      check("sim_p_gap", cyc, 5);
      check("sim_p_res", res_pairs, 2020);
      check("sim_t_keep", res_time, 505);
      @(negedge clk);
      req_pairs = 1'b0;

      // clamp boundaries
      single_op(1'b1, 6'd40, 33, 3333, "clamp40");
      single_op(1'b1, 6'd33, 33, 3333, "clamp33");
      single_op(1'b1, 6'd0, 0, 0, "clamp0");
      single_op(1'b0, 6'd63, 33, 3333, "clamp63");

      // round robin with both requests held
      do_reset();
      @(negedge clk);
      op_time = 6'd1; op_pairs = 6'd2; req_time = 1'b1; req_pairs = 1'b1;
      nd = 0; idle = 0;
      for (int c = 1; c <= 30 && nd < 4; c++) begin
         step();
         if (done_time || done_pairs) begin
            check($sformatf("rr_who%0d", nd), done_pairs, nd % 2);
            check($sformatf("rr_cyc%0d", nd), c, 4 + 5 * nd);
            nd++;
         end else if (!busy && nd > 0) begin
            idle++;
         end
      end
      check("rr_count", nd, 4);
      check("rr_idle", idle, 3);
      check("rr_res_t", res_time, 101);
      check("rr_res_p", res_pairs, 202);
      @(negedge clk);
      req_time = 1'b0; req_pairs = 1'b0;

      // abort: time granted, then dropped during WAIT; pairs pending
      @(negedge clk);
      op_time = 6'd9; op_pairs = 6'd3; req_time = 1'b1; req_pairs = 1'b1;
      step();
      check("ab_a_t", mult_a, 9);
      check("ab_start_t", mult_start, 1);
      step();
      @(negedge clk);
      req_time = 1'b0;
      step();
      step();
      check("ab_no_done", done_time, 0);
      check("ab_res_keep", res_time, 101);
      step();
      check("ab_idle", busy, 0);
      step();
      check("ab_start_p", mult_start, 1);
      check("ab_a_p", mult_a, 3);
      wait_done(1'b1, 12, cyc);
      check("ab_p_lat", cyc, 3);
      check("ab_p_res", res_pairs, 303);
      @(negedge clk);
      req_pairs = 1'b0;

      // async reset mid-WAIT, then a fresh request on the standard schedule
      @(negedge clk);
      op_time = 6'd30; req_time = 1'b1;
      step();
      step();
      #2;
      rst = 1'b0;
      #1;
      check("ar_outs", {mult_a, mult_start, res_time, done_time, res_pairs, done_pairs, busy}, 0);
      @(negedge clk);
      req_time = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      step();
      step();
      check("ar_ignore", {res_time, done_time, busy}, 0);
      single_op(1'b0, 6'd7, 7, 707, "ar_new");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule
